serial_byte_rx: RTL and testbench
=================================

Name: serial_byte_rx

Overview:
- Receives 8N1 asynchronous serial frames on a line that has already passed through the two-flop synchronizer (serial_in is its sync_out).
- Recovers each byte LSB-first by oversampling against a fixed clocks-per-bit count.
- Holds the byte with a ready flag until the consumer acknowledges it.
- Sits between the input synchronizer and the digit-recognizer input buffer.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; even, minimum 4
HALF_BIT, CLKS_PER_BIT/2, derived; cycles from start edge to start-bit mid-sample

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  reset, synchronous, active-low
serial_in  input  1  synchronized serial line, idle high
data_read  input  1  consumer acknowledge; clears data_ready and overrun_error
rx_data  output  8  last good received byte
data_ready  output  1  rx_data holds an unread byte
framing_error  output  1  last frame had stop bit = 0
overrun_error  output  1  a byte was loaded while data_ready was already 1

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, n_rst. All state changes occur on the rising edge of clk; no asynchronous paths.
- Reset (n_rst=0 at a clock edge), including mid-frame:
  - FSM goes to IDLE; counters clear.
  - rx_data=8'h00, data_ready=0, framing_error=0, overrun_error=0.
  - Edge-detect register prev_in resets to 0, so a start edge needs the line to be seen high first. The synchronizer's post-reset low therefore never triggers a frame.
- Start detect: edge E is the first clock edge where serial_in=0 and prev_in=1. prev_in <= serial_in every cycle.
- FSM states: IDLE, START, DATA, STOP, LOAD.
  - IDLE: on edge E, go to START, clear the bit counter and bit index, clear framing_error.
  - START: sample at E+HALF_BIT.
    - serial_in=0: go to DATA.
    - serial_in=1: glitch; return to IDLE, no flag changes.
  - DATA: bit k (k=0..7) sampled at E+HALF_BIT+(k+1)*CLKS_PER_BIT into shift register position k (LSB first). After k=7, go to STOP.
  - STOP: sample at E+HALF_BIT+9*CLKS_PER_BIT.
    - serial_in=1: go to LOAD.
    - serial_in=0: set framing_error=1, return to IDLE. rx_data and data_ready are unchanged.
  - LOAD: single cycle.
    - rx_data <= shift register; data_ready <= 1.
    - If data_ready was 1 and data_read=0 this cycle, set overrun_error=1 (new byte overwrites).
    - Go to IDLE.
  - rx_data and data_ready are visible the cycle after the LOAD edge, i.e. E+HALF_BIT+9*CLKS_PER_BIT+2.
- data_read:
  - At any clock edge with no load, clears data_ready and overrun_error.
  - data_read coincident with LOAD: load wins. data_ready stays 1, overrun_error is not set, previous overrun is cleared.
  - data_read while data_ready=0: no effect.
- Back-to-back frames: after STOP/LOAD, IDLE accepts a new edge immediately. prev_in keeps tracking in every state, so a start bit right after the stop bit is detected.
- After a framing error the line may still be low. No new frame starts until serial_in returns high and then falls.
- serial_in changes outside the sample points are ignored in all states except IDLE.
- Counters: the bit counter is wide enough for CLKS_PER_BIT-1; the bit index is 3 bits and does not wrap past 7.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> rx_data=8'hA5, data_ready=1 at E+8+144+2, both error flags 0; pulse data_read -> data_ready=0 next cycle.
- Line low for 4 cycles then high (glitch) -> FSM returns to IDLE at E+8, no flag changes; a following valid 0x3C frame is received correctly.
- Send 0x81 with stop bit 0 -> framing_error=1, data_ready stays 0, rx_data keeps its old value. Hold the line low 20 cycles, raise it, send 0x42 -> rx_data=8'h42, framing_error cleared at the new start edge.
- Send 0x11 then 0x22 without data_read -> rx_data=8'h22, data_ready=1, overrun_error=1. Then data_read -> both cleared.
- Send 0x55 with data_read asserted exactly on the LOAD cycle while holding an unread 0x11 -> rx_data=8'h55, data_ready=1, overrun_error=0.
- Assert n_rst=0 for one edge during bit 3 of a frame -> all outputs 0 next cycle. Remainder of the aborted frame produces no data_ready. The next complete frame 0xF0 is received correctly.

Source files
------------

// File: rtl/serial_byte_rx.sv
// serial_byte_rx: 8N1 serial byte receiver.
// Finds the start bit's falling edge, samples every bit at its middle using a
// fixed clocks-per-bit count, and holds the received byte with a ready flag
// until the consumer acknowledges it. Framing and overrun conditions are flagged.
module serial_byte_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       serial_in,
    input  logic       data_read,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       framing_error,
    output logic       overrun_error
);

    // Start edge to start-bit middle; every later sample is one full bit apart.
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    // Counter terminal values: the counter is cleared on the cycle a phase
    // begins, so a sample lands when it reaches (interval - 1).
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        LOAD
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             prev_in_reg;
    logic [7:0]       rx_reg, rx_next;
    logic             dr_reg, dr_next;
    logic             fe_reg, fe_next;
    logic             ov_reg, ov_next;

    // A start bit is a high-to-low transition; prev_in resets low so the line
    // has to be observed idle-high before any frame can begin.
    logic start_edge;
    assign start_edge = prev_in_reg & ~serial_in;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: counters, shift register, edge detector and outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_reg     <= '0;
            idx_reg     <= '0;
            shift_reg   <= '0;
            prev_in_reg <= 1'b0;
            rx_reg      <= '0;
            dr_reg      <= 1'b0;
            fe_reg      <= 1'b0;
            ov_reg      <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            shift_reg   <= shift_next;
            prev_in_reg <= serial_in;
            rx_reg      <= rx_next;
            dr_reg      <= dr_next;
            fe_reg      <= fe_next;
            ov_reg      <= ov_next;
        end
    end

    // Next-state and datapath update; the LOAD branch overrides the
    // acknowledge so a byte arriving with data_read stays marked ready.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        rx_next    = rx_reg;
        dr_next    = dr_reg;
        fe_next    = fe_reg;
        ov_next    = ov_reg;

        if (data_read) begin
            dr_next = 1'b0;
            ov_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (start_edge) begin
                    state_next = START;
                    cnt_next   = '0;
                    idx_next   = '0;
                    fe_next    = 1'b0;
                end
            end

            START: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next = '0;
                    // A high line at mid start bit means it was only a glitch.
                    state_next = serial_in ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            DATA: begin
                if (cnt_reg == CNT_FULL) begin
                    cnt_next            = '0;
                    shift_next[idx_reg] = serial_in;
                    if (idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            STOP: begin
                if (cnt_reg == CNT_FULL) begin
                    cnt_next = '0;
                    if (serial_in) begin
                        state_next = LOAD;
                    end else begin
                        fe_next    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            LOAD: begin
                rx_next    = shift_reg;
                dr_next    = 1'b1;
                // Overrun only when an unread byte is overwritten without ack.
                ov_next    = dr_reg & ~data_read;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx_data       = rx_reg;
    assign data_ready    = dr_reg;
    assign framing_error = fe_reg;
    assign overrun_error = ov_reg;

endmodule

// File: tb/tb_serial_byte_rx.sv
// Testbench for serial_byte_rx: directed frame table, hand-written corner
// sequences and randomized frames checked against a frame-level model.
module tb_serial_byte_rx;

    localparam int C = 16;
    localparam int H = C / 2;

    logic       clk;
    logic       n_rst;
    logic       serial_in;
    logic       data_read;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       framing_error;
    logic       overrun_error;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;

    // Frame-level reference model state.
    logic [7:0] exp_rx;
    logic       exp_dr, exp_fe, exp_ov;

    serial_byte_rx #(.CLKS_PER_BIT(C)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_rx"}, rx_data, exp_rx);
        chk({tag, "_dr"}, {7'd0, data_ready}, {7'd0, exp_dr});
        chk({tag, "_fe"}, {7'd0, framing_error}, {7'd0, exp_fe});
        chk({tag, "_ov"}, {7'd0, overrun_error}, {7'd0, exp_ov});
    endtask

    task automatic model_reset();
        exp_rx = 8'h00;
        exp_dr = 1'b0;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
    endtask

    // Drives one whole frame starting at a negedge; checks the start-edge flag
    // clear and the exact cycle the byte becomes visible, then updates the model.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_load);
        serial_in = 1'b0;
        @(negedge clk);
        chk("fe_clear_at_start", {7'd0, framing_error}, 8'd0);
        cyc(C - 1);
        for (int k = 0; k < 8; k++) begin
            serial_in = d[k];
            cyc(C);
        end
        serial_in = stop;
        for (int i = 1; i <= C; i++) begin
            @(negedge clk);
            if (i == H + 1) begin
                chk("dr_before_load", {7'd0, data_ready}, {7'd0, exp_dr});
                chk("fe_after_stop", {7'd0, framing_error}, {7'd0, ~stop});
                data_read = ack_load;
            end
            if (i == H + 2) begin
                data_read = 1'b0;
                if (stop) begin
                    chk("dr_at_load_latency", {7'd0, data_ready}, 8'd1);
                    chk("rx_at_load_latency", rx_data, d);
                end
            end
        end
        if (stop) begin
            exp_ov = exp_dr & ~ack_load;
            exp_dr = 1'b1;
            exp_rx = d;
            exp_fe = 1'b0;
        end else begin
            exp_fe = 1'b1;
            if (ack_load) begin
                exp_dr = 1'b0;
                exp_ov = 1'b0;
            end
        end
        frame_no++;
        $display("frame %0d data=%h stop=%b ack_load=%b -> rx=%h dr=%b fe=%b ov=%b",
                 frame_no, d, stop, ack_load, rx_data, data_ready, framing_error, overrun_error);
    endtask

    // Returns the line to idle after a frame, optionally acknowledges, then idles.
    task automatic finish_frame(input logic stop, input int tail_low, input logic ack_after, input int gap);
        if (!stop) begin
            cyc(tail_low);
            serial_in = 1'b1;
            cyc(1);
        end
        if (ack_after) begin
            data_read = 1'b1;
            cyc(1);
            data_read = 1'b0;
            exp_dr = 1'b0;
            exp_ov = 1'b0;
        end
        cyc(gap);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ack_load;
        int         tail_low;
        logic       ack_after;
        logic [7:0] e_rx;
        logic       e_dr;
        logic       e_fe;
        logic       e_ov;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 0,  1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h81, 1'b0, 1'b0, 20, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h42, 1'b1, 1'b0, 0,  1'b1, 8'h42, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h11, 1'b1, 1'b0, 0,  1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h22, 1'b1, 1'b0, 0,  1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h11, 1'b1, 1'b0, 0,  1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h55, 1'b1, 1'b1, 0,  1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h66, 1'b1, 1'b0, 0,  1'b0, 8'h66, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{8'h77, 1'b1, 1'b1, 0,  1'b1, 8'h77, 1'b1, 1'b0, 1'b0};

        // Reset with the line low, as the synchronizer presents it after reset.
        n_rst     = 1'b0;
        serial_in = 1'b0;
        data_read = 1'b0;
        model_reset();
        cyc(3);
        chk_model("reset");
        n_rst = 1'b1;
        cyc(40);
        serial_in = 1'b1;
        cyc(200);
        chk("no_frame_from_reset_low", {7'd0, data_ready}, 8'd0);

        // Directed frame table.
        for (int v = 0; v < 9; v++) begin
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].ack_load);
            chk("tbl_rx", rx_data, vecs[v].e_rx);
            chk("tbl_dr", {7'd0, data_ready}, {7'd0, vecs[v].e_dr});
            chk("tbl_fe", {7'd0, framing_error}, {7'd0, vecs[v].e_fe});
            chk("tbl_ov", {7'd0, overrun_error}, {7'd0, vecs[v].e_ov});
            finish_frame(vecs[v].stop, vecs[v].tail_low, vecs[v].ack_after, 3);
            if (vecs[v].ack_after) begin
                chk("tbl_ack_dr", {7'd0, data_ready}, 8'd0);
                chk("tbl_ack_ov", {7'd0, overrun_error}, 8'd0);
            end
        end

        // Glitch: line low for 4 cycles only, then a valid frame.
        serial_in = 1'b0;
        cyc(4);
        serial_in = 1'b1;
        cyc(12);
        exp_fe = 1'b0;
        chk_model("glitch");
        cyc(5);
        send_frame(8'h3C, 1'b1, 1'b0);
        chk_model("after_glitch");
        finish_frame(1'b1, 0, 1'b1, 2);

        // Randomized frames against the model, including back-to-back starts.
        for (int r = 0; r < 40; r++) begin
            logic [7:0] d;
            logic       st, al, aa;
            int         gap, tl;
            d   = 8'($urandom);
            st  = ($urandom_range(0, 4) != 0);
            al  = ($urandom_range(0, 3) == 0);
            aa  = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 12);
            tl  = $urandom_range(0, 15);
            send_frame(d, st, al);
            chk_model("rand_frame");
            finish_frame(st, tl, aa, gap);
            chk_model("rand_idle");
        end

        // Reset in the middle of bit 3 while holding an unread, overrun byte.
        send_frame(8'h99, 1'b1, 1'b0);
        finish_frame(1'b1, 0, 1'b0, 0);
        send_frame(8'h99, 1'b1, 1'b0);
        finish_frame(1'b1, 0, 1'b0, 2);
        chk_model("pre_abort");
        begin
            logic [7:0] ab;
            ab = 8'hF8;
            serial_in = 1'b0;
            cyc(C);
            for (int k = 0; k < 3; k++) begin
                serial_in = ab[k];
                cyc(C);
            end
            serial_in = ab[3];
            cyc(H);
            n_rst = 1'b0;
            cyc(1);
            n_rst = 1'b1;
            model_reset();
            chk_model("mid_frame_reset");
            cyc(C - H - 1);
            for (int k = 4; k < 8; k++) begin
                serial_in = ab[k];
                cyc(C);
            end
            serial_in = 1'b1;
            cyc(3 * C);
            chk_model("aborted_remainder");
        end
        send_frame(8'hF0, 1'b1, 1'b0);
        chk_model("after_abort");
        finish_frame(1'b1, 0, 1'b1, 2);
        chk_model("final_ack");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
